ap_hs_txn_recorder: RTL and testbench
=====================================

# ap_hs_txn_recorder

Synthesizable transaction recorder for one HLS `ap_ctrl_hs` block (e.g. the max-pool top or its pipelined loop). It taps the block's start/done handshake and a per-iteration pulse, measures start time, latency, start-to-start interval and iteration count per transaction, and queues one fixed-width record per transaction in an internal FIFO. The record stream feeds the status dumper / AXI readout downstream, giving on-board the same module/loop status a simulation monitor produces.

## Interface
- `CW`, 32: width of the cycle timer and of the time, latency and interval fields.
- `DEPTH`, 16: record FIFO depth; power of two, ≥2.
- `ap_clk`  in  1  clock.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `ap_start`  in  1  monitored block's ap_start.
- `ap_done`  in  1  monitored block's ap_done.
- `ap_continue`  in  1  monitored block's ap_continue; tie 1 if absent.
- `iter_pulse`  in  1  one-cycle pulse per loop iteration completed (e.g. enable of last pipeline stage & !block).
- `finish`  in  1  end-of-run; closes an open transaction.
- `rec_valid`  out  1  FIFO head valid.
- `rec_ready`  in  1  consumer accepts head.
- `rec_data`  out  1+16+16+3·CW  {incomplete, txn_id[15:0], iter_cnt[15:0], start_time, latency, interval}, MSB first.
- `drop_cnt`  out  16  records lost to FIFO full, saturating.
- `busy`  out  1  transaction open.

## Operation
- Free-running `timer` (CW bits) increments every cycle, wraps modulo 2^CW.
- FSM states IDLE, RUN, CLOSED.
  - IDLE: `ap_start`=1 → RUN; latch `t_start`=timer; interval = timer − `t_prev` (mod 2^CW), or 0 for first transaction since reset; `t_prev`=timer; `iter_cnt` cleared to 0, plus 1 if `iter_pulse` this cycle.
  - RUN: `iter_pulse` increments `iter_cnt` (saturates at 0xFFFF). `ap_done && ap_continue` → build record (incomplete=0, latency = timer − `t_start` mod 2^CW), push, → IDLE. `ap_done` with `ap_continue`=0: stay RUN, latency keeps growing until the accepting cycle. `finish`=1 with no accepting done → push record with incomplete=1, latency to current cycle, → CLOSED.
  - IDLE with `finish`=1 → CLOSED. CLOSED: ignores all inputs until reset; FIFO still drains.
- `ap_start` while RUN is ignored (block not ready); a new transaction opens no earlier than the cycle after done is accepted.
- `txn_id` increments by 1 (wraps at 16 bits) on every record built, whether pushed or dropped.
- Push when FIFO full: record discarded, `drop_cnt` +1 (saturates 0xFFFF); no stall of anything.
- Push and pop in same cycle when full: pop frees a slot, push succeeds, no drop.
- `busy` = (state == RUN).

## Timing
- Reset (async assert, sync release): timer=0, state IDLE, FIFO empty, `rec_valid`=0, `rec_data`=0, `drop_cnt`=0, `busy`=0, txn_id=0, first-transaction flag set.
- Start cycle S (sampled on edge where `ap_start`=1 in IDLE): `busy`=1 from S+1.
- Done accepted at cycle D: record written at edge ending D; `rec_valid`=1 from D+1 if FIFO was empty; `busy`=0 from D+1.
- FIFO is first-word-fall-through, registered output; pop on `rec_valid && rec_ready`; next entry visible the following cycle. Throughput 1 record/cycle.
- `rec_data` holds steady while `rec_valid`=1 and `rec_ready`=0.
- Reset mid-transaction: open transaction and FIFO contents discarded, no record emitted.

## Test plan
- Single transaction: start at timer=10, 4 iter pulses, done+continue at timer=25 → one record {0, 0, 4, 10, 15, 0}; `busy` high cycles 11–25.
- Back-to-back: done at 25, start held high → next start at 26, record 2 interval=16, txn_id=1.
- Continue held low 3 cycles after done at 25 → latency 18; no record until acceptance.
- `rec_ready`=0, 18 transactions with DEPTH=16 → 16 records retained, `drop_cnt`=2, drained ids 0–15 in order; ids 16,17 lost; next record id 18.
- `finish` during RUN at latency 7 → record incomplete=1, latency=7; later `ap_start` ignored.
- Timer wrap (CW=8): start at 250, done at 4 → latency 10; async reset mid-RUN → outputs return to reset values immediately.

Source files
------------

// File: rtl/ap_hs_txn_recorder.sv
// rtl/ap_hs_txn_recorder.sv - ap_ctrl_hs transaction recorder with record FIFO
// Measures start time, latency, interval and iteration count per transaction.
module ap_hs_txn_recorder #(
  parameter int CW    = 32,
  parameter int DEPTH = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic              ap_done,
  input  logic              ap_continue,
  input  logic              iter_pulse,
  input  logic              finish,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [32+3*CW:0]  rec_data,
  output logic [15:0]       drop_cnt,
  output logic              busy
);
  localparam int RW = 33 + 3*CW;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CLOSED = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   timer, t_start, t_prev, interval, latency_now;
  logic            first;
  logic [15:0]     iter_cnt, iter_inc, txn_id;
  logic            done_acc, do_start, do_close, incomplete;
  logic [RW-1:0]   rec_new;
  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, push, pop;

  assign done_acc = ap_done && ap_continue;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (finish)        state_nxt = CLOSED;
        else if (ap_start) state_nxt = RUN;
      end
      RUN: begin
        if (done_acc)    state_nxt = IDLE;
        else if (finish) state_nxt = CLOSED;
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    busy       = (state == RUN);
    do_start   = (state == IDLE) && ap_start && !finish;
    do_close   = (state == RUN) && (done_acc || finish);
    incomplete = !done_acc;
  end

  // A pulse in the closing cycle still counts toward the record
  assign iter_inc    = (iter_pulse && iter_cnt != 16'hFFFF) ? iter_cnt + 16'd1 : iter_cnt;
  assign latency_now = timer - t_start;
  assign rec_new     = {incomplete, txn_id, iter_inc, t_start, latency_now, interval};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      timer    <= '0;
      t_start  <= '0;
      t_prev   <= '0;
      interval <= '0;
      first    <= 1'b1;
      iter_cnt <= '0;
      txn_id   <= '0;
      drop_cnt <= '0;
    end else begin
      timer <= timer + 1'b1;
      if (do_start) begin
        t_start  <= timer;
        interval <= first ? '0 : timer - t_prev;
        t_prev   <= timer;
        first    <= 1'b0;
        iter_cnt <= {15'd0, iter_pulse};
      end else if (busy) begin
        iter_cnt <= iter_inc;
      end
      if (do_close) begin
        txn_id <= txn_id + 16'd1;
        if (!push && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // A pop in the same cycle frees the slot a full-FIFO push needs
  assign full      = (count == FULL_CNT);
  assign rec_valid = (count != '0);
  assign pop       = rec_valid && rec_ready;
  assign push      = do_close && (!full || pop);
  assign rec_data  = rec_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= rec_new;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_ap_hs_txn_recorder.sv
// tb/tb_ap_hs_txn_recorder.sv - transaction-level model bench for ap_hs_txn_recorder
module tb_ap_hs_txn_recorder;
  localparam int CW    = 8;
  localparam int DEPTH = 16;
  localparam int RW    = 33 + 3*CW;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n, ap_start, ap_done, ap_continue, iter_pulse, finish;
  logic          rec_valid, rec_ready, busy;
  logic [RW-1:0] rec_data;
  logic [15:0]   drop_cnt;

  ap_hs_txn_recorder #(.CW(CW), .DEPTH(DEPTH)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_continue(ap_continue), .iter_pulse(iter_pulse), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;
  int now    = 0;

  // Transaction-level model: open/closed flags, timestamps and an expected record queue
  logic [RW-1:0] q[$];
  bit            m_open, m_closed, m_first;
  logic [CW-1:0] m_time, m_tstart, m_tprev, m_int;
  int            m_iter, m_drop;
  logic [15:0]   m_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, now);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_open = 0; m_closed = 0; m_first = 1;
    m_time = '0; m_tstart = '0; m_tprev = '0; m_int = '0;
    m_iter = 0; m_drop = 0; m_id = '0;
  endtask

  task automatic model_step();
    bit            pop, close, inc;
    int            iters;
    logic [RW-1:0] rec;
    pop = (q.size() != 0) && rec_ready;
    close = 0; inc = 0; iters = m_iter;
    if (!m_closed) begin
      if (m_open) begin
        iters = (iter_pulse && m_iter < 65535) ? m_iter + 1 : m_iter;
        m_iter = iters;
        if (ap_done && ap_continue) close = 1;
        else if (finish) begin close = 1; inc = 1; m_closed = 1; end
        if (close) m_open = 0;
      end else if (finish) begin
        m_closed = 1;
      end else if (ap_start) begin
        m_open = 1;
        m_int = m_first ? '0 : m_time - m_tprev;
        m_tstart = m_time; m_tprev = m_time; m_first = 0;
        m_iter = iter_pulse ? 1 : 0;
      end
    end
    if (pop) void'(q.pop_front());
    if (close) begin
      rec = {inc, m_id, 16'(iters), m_tstart, m_time - m_tstart, m_int};
      m_id = m_id + 16'd1;
      if (q.size() < DEPTH) q.push_back(rec);
      else if (m_drop < 65535) m_drop++;
    end
    m_time = m_time + 1'b1;
  endtask

  task automatic check_model();
    chk("busy", 64'(busy), 64'(m_open));
    chk("rec_valid", 64'(rec_valid), 64'(q.size() != 0));
    chk("rec_data", 64'(rec_data), (q.size() != 0) ? 64'(q[0]) : 64'd0);
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic cycle();
    @(posedge ap_clk);
    if (ap_rst_n) model_step(); else model_reset();
    @(negedge ap_clk);
    now++;
    if (ap_rst_n) check_model();
  endtask

  int s;

  initial begin
    ap_rst_n = 0; ap_start = 0; ap_done = 0; ap_continue = 1;
    iter_pulse = 0; finish = 0; rec_ready = 1;
    model_reset();
    repeat (3) cycle();
    ap_rst_n = 1; now = 0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rec_data", 64'(rec_data), 64'd0);

    // Single transaction, then back-to-back start with held ap_start
    while (now < 10) cycle();
    chk("busy_before_start", 64'(busy), 64'd0);
    ap_start = 1;
    cycle();
    chk("busy_at_11", 64'(busy), 64'd1);
    cycle();
    iter_pulse = 1;
    repeat (4) cycle();
    iter_pulse = 0;
    while (now < 25) cycle();
    chk("busy_at_25", 64'(busy), 64'd1);
    chk("no_rec_before_done", 64'(rec_valid), 64'd0);
    ap_done = 1;
    cycle();
    ap_done = 0;
    chk("busy_at_26", 64'(busy), 64'd0);
    chk("rec1", 64'(rec_data), 64'({1'b0, 16'd0, 16'd4, 8'd10, 8'd15, 8'd0}));
    iter_pulse = 1;
    cycle();
    ap_start = 0; iter_pulse = 0;
    chk("busy_txn2", 64'(busy), 64'd1);

    // Done held off by ap_continue for three cycles
    while (now < 41) cycle();
    ap_done = 1; ap_continue = 0;
    repeat (3) cycle();
    chk("no_rec_while_blocked", 64'(rec_valid), 64'd0);
    ap_continue = 1;
    cycle();
    ap_done = 0;
    chk("rec2", 64'(rec_data), 64'({1'b0, 16'd1, 16'd1, 8'd26, 8'd18, 8'd16}));

    // Async reset with a queued record and an open transaction
    rec_ready = 0;
    while (now < 50) cycle();
    ap_start = 1; cycle();
    ap_start = 0; cycle();
    ap_done = 1;  cycle();
    ap_done = 0; ap_start = 1; cycle();
    ap_start = 0;
    repeat (2) cycle();
    chk("queued_before_reset", 64'(rec_valid), 64'd1);
    #2 ap_rst_n = 0;
    model_reset();
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rec_valid", 64'(rec_valid), 64'd0);
    chk("rst_rec_data", 64'(rec_data), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    cycle();
    ap_rst_n = 1; now = 0;

    // Overflow: 18 transactions into a 16-deep FIFO with no consumer
    for (int k = 0; k < 18; k++) begin
      ap_start = 1; iter_pulse = k[0];
      cycle();
      ap_start = 0; iter_pulse = 1;
      cycle();
      iter_pulse = 0;
      cycle();
      ap_done = 1;
      cycle();
      ap_done = 0;
      cycle();
    end
    chk("drop_after_18", 64'(drop_cnt), 64'd2);
    chk("full_valid", 64'(rec_valid), 64'd1);
    ap_start = 1; cycle();
    ap_start = 0; cycle();
    ap_done = 1; rec_ready = 1;
    chk("head_id0", 64'(rec_data[RW-2 -: 16]), 64'd0);
    cycle();
    ap_done = 0;
    for (int j = 1; j < 16; j++) begin
      chk("drain_id", 64'(rec_data[RW-2 -: 16]), 64'(j));
      cycle();
    end
    chk("drain_id18", 64'(rec_data[RW-2 -: 16]), 64'd18);
    cycle();
    chk("drained_empty", 64'(rec_valid), 64'd0);
    chk("drop_unchanged", 64'(drop_cnt), 64'd2);

    // finish during RUN closes an incomplete record; later starts are ignored
    ap_start = 1; s = now;
    cycle();
    ap_start = 0;
    while (now < s + 7) cycle();
    finish = 1;
    cycle();
    finish = 0;
    chk("finish_incomplete", 64'(rec_data[RW-1]), 64'd1);
    chk("finish_latency", 64'(rec_data[2*CW-1 -: CW]), 64'd7);
    ap_start = 1;
    repeat (3) begin
      cycle();
      chk("closed_ignores_start", 64'(busy), 64'd0);
    end
    ap_start = 0;

    // Timer wrap on a fresh reset: start at 250, done at timer 4
    ap_rst_n = 0;
    cycle();
    ap_rst_n = 1; now = 0;
    while (now < 250) cycle();
    ap_start = 1; cycle();
    ap_start = 0;
    while (now < 260) cycle();
    ap_done = 1; cycle();
    ap_done = 0;
    chk("wrap_start", 64'(rec_data[3*CW-1 -: CW]), 64'd250);
    chk("wrap_latency", 64'(rec_data[2*CW-1 -: CW]), 64'd10);
    chk("wrap_interval", 64'(rec_data[CW-1:0]), 64'd0);
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
